// File: rtl/div_unit_pkg.sv
// Shared opcode and state definitions for the iterative RV32M divider.
package div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_S_IDLE = 2'b00,
    DIV_S_CALC = 2'b01,
    DIV_S_FIN  = 2'b10,
    DIV_S_DONE = 2'b11
  } div_state_e;

  // funct3[0] clear selects the signed variants (DIV/REM).
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration on the {R,Q} register pair.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] r_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0] r_shift;
  logic [XLEN:0] trial;

  // The shifted remainder can reach 2*b-1, so it keeps R's old MSB.
  assign r_shift = {r, q[XLEN-1]};
  assign trial   = r_shift - {1'b0, b};

  always_comb begin
    r_next = r_shift[XLEN-1:0];
    q_next = {q[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      r_next    = trial[XLEN-1:0];
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with start/done handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_reg, state_next;
  logic [XLEN-1:0] r_reg, q_reg, b_reg, result_reg;
  logic [CNT_W-1:0] count_reg;
  logic            rem_sel_reg, neg_q_reg, neg_r_reg;

  logic [XLEN-1:0] r_step, q_step;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            accept, signed_op, div_zero, overflow, special;

  assign accept    = start_i && ((state_reg == DIV_S_IDLE) || (state_reg == DIV_S_DONE));
  assign signed_op = is_signed_op(op_i);
  assign a_abs     = (signed_op && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_abs     = (signed_op && b_i[XLEN-1]) ? -b_i : b_i;
  assign div_zero  = (b_i == '0);
  assign overflow  = signed_op && (a_i == MIN_NEG) && (b_i == '1);
  assign special   = div_zero || overflow;

  div_step #(.XLEN(XLEN)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .b      (b_reg),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DIV_S_IDLE: if (accept) state_next = special ? DIV_S_FIN : DIV_S_CALC;
      DIV_S_CALC: if (count_reg == '1) state_next = DIV_S_FIN;
      DIV_S_FIN:  state_next = DIV_S_DONE;
      DIV_S_DONE: begin
        if (accept) state_next = special ? DIV_S_FIN : DIV_S_CALC;
        else        state_next = DIV_S_IDLE;
      end
      default:    state_next = DIV_S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= DIV_S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_reg       <= '0;
      q_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      count_reg   <= '0;
      rem_sel_reg <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
    end else if (accept) begin
      rem_sel_reg <= op_i[1];
      b_reg       <= b_abs;
      count_reg   <= '0;
      // Special results are final values; sign fix-up must not touch them.
      if (div_zero) begin
        q_reg     <= '1;
        r_reg     <= a_i;
        neg_q_reg <= 1'b0;
        neg_r_reg <= 1'b0;
      end else if (overflow) begin
        q_reg     <= MIN_NEG;
        r_reg     <= '0;
        neg_q_reg <= 1'b0;
        neg_r_reg <= 1'b0;
      end else begin
        q_reg     <= a_abs;
        r_reg     <= '0;
        neg_q_reg <= signed_op && (a_i[XLEN-1] ^ b_i[XLEN-1]);
        neg_r_reg <= signed_op && a_i[XLEN-1];
      end
    end else if (state_reg == DIV_S_CALC) begin
      r_reg     <= r_step;
      q_reg     <= q_step;
      count_reg <= count_reg + CNT_W'(1);
    end else if (state_reg == DIV_S_FIN) begin
      if (rem_sel_reg) result_reg <= neg_r_reg ? -r_reg : r_reg;
      else             result_reg <= neg_q_reg ? -q_reg : q_reg;
    end
  end

  assign busy_o   = (state_reg == DIV_S_CALC) || (state_reg == DIV_S_FIN);
  assign done_o   = (state_reg == DIV_S_DONE);
  assign result_o = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: results, latency, busy, back-to-back and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Drive a request so it is sampled on the next edge (E0); return 1ns after E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
  endtask

  // Count edges after E0 until done_o is seen; 'already' edges have elapsed.
  task automatic wait_done(input int already, output int lat, output logic busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = already + 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic busy_ok;
    @(negedge clk);
    start_op(o, x, y);
    check({tag, " busy@E0"}, 32'(busy), 32'd1);
    wait_done(0, lat, busy_ok);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, 32'(busy_ok), 32'd1);
    check({tag, " result"}, result, exp);
  endtask

  initial begin
    int lat;
    logic busy_ok;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    run_op("DIVU 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIV -7/2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("REM 7/-2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("DIV 7/-2", DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("DIVU max/1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("DIVU max/2^31", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 33);
    run_op("REMU max/2^31", DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);
    run_op("DIV min/2", DIV_OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
    run_op("DIVU 5/0", DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU 5/0", DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV -5/0", DIV_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REM -5/0", DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run_op("DIV ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // done_o is a single-cycle pulse when no new request follows.
    @(posedge clk); #1;
    check("done pulse width", 32'(done), 32'd0);

    // A start during CALC is ignored; a start during DONE is accepted.
    @(negedge clk);
    start_op(DIV_OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    op = DIV_OP_DIVU; a = 32'd9; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h1234_5678; b = 32'd5;
    wait_done(10, lat, busy_ok);
    check("ignore latency", 32'(lat), 32'd33);
    check("ignore result", result, 32'd14);
    start_op(DIV_OP_DIVU, 32'd9, 32'd3);
    check("b2b busy@E0", 32'(busy), 32'd1);
    wait_done(0, lat, busy_ok);
    check("b2b latency", 32'(lat), 32'd33);
    check("b2b result", result, 32'd3);

    // Reset mid-CALC discards the operation.
    @(negedge clk);
    start_op(DIV_OP_DIVU, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", result, 32'd0);
    wait_done(0, lat, busy_ok);
    check("midrst no done", 32'(lat), 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
